// File: rtl/cdb_pkg.sv
// Shared types and constants for the common-data-bus writeback arbiter.
package cdb_pkg;

    localparam int unsigned PRF_IDX_W = 6;
    localparam int unsigned ROB_IDX_W = 5;
    localparam int unsigned BR_MASK_W = 4;
    localparam int unsigned VALUE_W   = 64;

    // Writeback requester indices
    localparam int unsigned REQ_ALU  = 0;
    localparam int unsigned REQ_MULT = 1;
    localparam int unsigned REQ_LDST = 2;
    localparam int unsigned REQ_BR   = 3;

    typedef struct packed {
        logic                 vld;
        logic [PRF_IDX_W-1:0] tag;
        logic [VALUE_W-1:0]   value;
        logic [ROB_IDX_W:0]   rob_idx;
        logic [BR_MASK_W-1:0] br_mask;
    } cdb_pkt_t;

    // True when a packet depends on the resolving branch
    function automatic logic mask_hit(input logic [BR_MASK_W-1:0] mask,
                                      input logic [BR_MASK_W-1:0] fix);
        return |(mask & fix);
    endfunction

endpackage

// File: rtl/cdb_rr_arb.sv
// One-of-N grant selection for the CDB. Round-robin by default; defining
// CDB_ARB_FIXED_PRI_EN selects fixed lowest-index-first priority instead.
module cdb_rr_arb #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);

`ifdef CDB_ARB_FIXED_PRI_EN

    logic found;
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

`else

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic             found;
    int unsigned      idx;

    // Search begins at ptr_q; the pointer moves past the winner only on a grant
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                ptr_d      = (idx + 1 == NUM_REQ) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`endif

endmodule

// File: rtl/cdb_arb.sv
// CDB writeback arbiter: one holding entry per requester, branch squash/resolve
// on stored masks, and a combinational broadcast of the granted entry.
// Build option: CDB_ARB_FIXED_PRI_EN selects fixed-priority arbitration.
module cdb_arb
    import cdb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_vld_i,
    input  logic [NUM_REQ-1:0][PRF_IDX_W-1:0]   req_tag_i,
    input  logic [NUM_REQ-1:0][VALUE_W-1:0]     req_value_i,
    input  logic [NUM_REQ-1:0][ROB_IDX_W:0]     req_rob_idx_i,
    input  logic [NUM_REQ-1:0][BR_MASK_W-1:0]   req_br_mask_i,
    output logic [NUM_REQ-1:0]                  req_rdy_o,
    input  logic                                rob_br_recovery_i,
    input  logic                                rob_br_pred_correct_i,
    input  logic [BR_MASK_W-1:0]                rob_br_tag_fix_i,
    output logic                                cdb_vld_o,
    output logic [PRF_IDX_W-1:0]                cdb_tag_o,
    output logic [VALUE_W-1:0]                  cdb_value_o,
    output logic [ROB_IDX_W:0]                  cdb_rob_idx_o,
    output logic [NUM_REQ-1:0]                  cdb_grant_o
);

    cdb_pkt_t             ent_q [NUM_REQ];
    cdb_pkt_t             ent_d [NUM_REQ];
    cdb_pkt_t             out_pkt;
    logic [NUM_REQ-1:0]   arb_req;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   squash_ent;
    logic [NUM_REQ-1:0]   squash_in;
    logic [NUM_REQ-1:0]   accept;
    logic [BR_MASK_W-1:0] clr_mask;
    logic [BR_MASK_W-1:0] unused_br_mask;

    // Recovery overrides a simultaneous resolve
    assign clr_mask = (rob_br_pred_correct_i && !rob_br_recovery_i) ? ~rob_br_tag_fix_i : '1;

    // No arbitration while in reset or during a squash cycle
    always_comb begin
        arb_req    = '0;
        squash_ent = '0;
        squash_in  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            arb_req[i]    = ent_q[i].vld && !rst && !rob_br_recovery_i;
            squash_ent[i] = rob_br_recovery_i && ent_q[i].vld
                            && mask_hit(ent_q[i].br_mask, rob_br_tag_fix_i);
            squash_in[i]  = rob_br_recovery_i && mask_hit(req_br_mask_i[i], rob_br_tag_fix_i);
        end
    end

    cdb_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (arb_req),
        .grant (grant)
    );

    // Entry update: refill wins over grant/squash so a granted slot never bubbles
    always_comb begin
        req_rdy_o = '0;
        accept    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            ent_d[i]         = ent_q[i];
            ent_d[i].br_mask = ent_q[i].br_mask & clr_mask;
            req_rdy_o[i]     = !rst && (!ent_q[i].vld || grant[i] || squash_ent[i] || squash_in[i]);
            accept[i]        = req_vld_i[i] && req_rdy_o[i] && !squash_in[i];
            if (accept[i]) begin
                ent_d[i].vld     = 1'b1;
                ent_d[i].tag     = req_tag_i[i];
                ent_d[i].value   = req_value_i[i];
                ent_d[i].rob_idx = req_rob_idx_i[i];
                ent_d[i].br_mask = req_br_mask_i[i] & clr_mask;
            end else if (grant[i] || squash_ent[i]) begin
                ent_d[i].vld = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    // Grant is one-hot or zero, so the mux yields all-zero when idle
    always_comb begin
        out_pkt = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                out_pkt = ent_q[i];
            end
        end
    end

    assign cdb_vld_o      = out_pkt.vld;
    assign cdb_tag_o      = out_pkt.tag;
    assign cdb_value_o    = out_pkt.value;
    assign cdb_rob_idx_o  = out_pkt.rob_idx;
    assign cdb_grant_o    = grant;
    assign unused_br_mask = out_pkt.br_mask;

endmodule

// File: tb/tb_cdb_arb.sv
// Directed self-checking bench for cdb_arb (default round-robin build).
module tb_cdb_arb;
    import cdb_pkg::*;

    localparam int unsigned N = 4;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [N-1:0]                  req_vld_i;
    logic [N-1:0][PRF_IDX_W-1:0]   req_tag_i;
    logic [N-1:0][VALUE_W-1:0]     req_value_i;
    logic [N-1:0][ROB_IDX_W:0]     req_rob_idx_i;
    logic [N-1:0][BR_MASK_W-1:0]   req_br_mask_i;
    logic [N-1:0]                  req_rdy_o;
    logic                          rob_br_recovery_i;
    logic                          rob_br_pred_correct_i;
    logic [BR_MASK_W-1:0]          rob_br_tag_fix_i;
    logic                          cdb_vld_o;
    logic [PRF_IDX_W-1:0]          cdb_tag_o;
    logic [VALUE_W-1:0]            cdb_value_o;
    logic [ROB_IDX_W:0]            cdb_rob_idx_o;
    logic [N-1:0]                  cdb_grant_o;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    int   n_sent;
    int   n_recv;
    logic saw_stall;
    logic fire;

    cdb_arb #(.NUM_REQ(N)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .req_vld_i             (req_vld_i),
        .req_tag_i             (req_tag_i),
        .req_value_i           (req_value_i),
        .req_rob_idx_i         (req_rob_idx_i),
        .req_br_mask_i         (req_br_mask_i),
        .req_rdy_o             (req_rdy_o),
        .rob_br_recovery_i     (rob_br_recovery_i),
        .rob_br_pred_correct_i (rob_br_pred_correct_i),
        .rob_br_tag_fix_i      (rob_br_tag_fix_i),
        .cdb_vld_o             (cdb_vld_o),
        .cdb_tag_o             (cdb_tag_o),
        .cdb_value_o           (cdb_value_o),
        .cdb_rob_idx_o         (cdb_rob_idx_o),
        .cdb_grant_o           (cdb_grant_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_vld_i             = '0;
        req_tag_i             = '0;
        req_value_i           = '0;
        req_rob_idx_i         = '0;
        req_br_mask_i         = '0;
        rob_br_recovery_i     = 1'b0;
        rob_br_pred_correct_i = 1'b0;
        rob_br_tag_fix_i      = '0;
    endtask

    task automatic offer(input int i, input int tag, input logic [63:0] val,
                         input logic [BR_MASK_W-1:0] mask);
        req_vld_i[i]     = 1'b1;
        req_tag_i[i]     = PRF_IDX_W'(tag);
        req_value_i[i]   = val;
        req_rob_idx_i[i] = (ROB_IDX_W+1)'(tag);
        req_br_mask_i[i] = mask;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        req_vld_i = '1;

        // Reset holds every output low even with requests present
        @(negedge clk);
        chk("rst_rdy",   64'(req_rdy_o),   64'h0);
        chk("rst_vld",   64'(cdb_vld_o),   64'h0);
        chk("rst_grant", 64'(cdb_grant_o), 64'h0);
        tick();
        tick();
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("idle_rdy", 64'(req_rdy_o), 64'hf);
        chk("idle_vld", 64'(cdb_vld_o), 64'h0);
        chk("idle_tag", 64'(cdb_tag_o), 64'h0);

        // Single ALU packet, broadcast one cycle after acceptance
        offer(REQ_ALU, 5, 64'h1234, 4'b0000);
        tick();
        idle();
        @(negedge clk);
        chk("single_vld",   64'(cdb_vld_o),     64'h1);
        chk("single_tag",   64'(cdb_tag_o),     64'h5);
        chk("single_value", cdb_value_o,        64'h1234);
        chk("single_rob",   64'(cdb_rob_idx_o), 64'h5);
        chk("single_grant", 64'(cdb_grant_o),   64'h1);
        tick();
        @(negedge clk);
        chk("single_empty", 64'(cdb_vld_o), 64'h0);

        // Reset with three entries full discards them; pointer was at 1
        offer(REQ_MULT, 11, 64'h11, 4'b0000);
        offer(REQ_LDST, 12, 64'h12, 4'b0000);
        offer(REQ_BR,   13, 64'h13, 4'b0000);
        tick();
        idle();
        @(negedge clk);
        chk("pre_rst_grant", 64'(cdb_grant_o), 64'h2);
        chk("pre_rst_tag",   64'(cdb_tag_o),   64'd11);
        rst = 1'b1;
        #1;
        chk("mid_rst_vld",   64'(cdb_vld_o),   64'h0);
        chk("mid_rst_rdy",   64'(req_rdy_o),   64'h0);
        chk("mid_rst_grant", 64'(cdb_grant_o), 64'h0);
        tick();
        @(negedge clk);
        chk("rst2_vld", 64'(cdb_vld_o), 64'h0);
        chk("rst2_rdy", 64'(req_rdy_o), 64'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_vld", 64'(cdb_vld_o), 64'h0);
        chk("post_rst_rdy", 64'(req_rdy_o), 64'hf);

        // Fairness: all four held valid, pointer restarted at 0
        for (int i = 0; i < 4; i++) offer(i, 16 + i, 64'(i), 4'b0000);
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_grant", 64'(cdb_grant_o), 64'(1 << (k % 4)));
            chk("rr_tag",   64'(cdb_tag_o),   64'(16 + (k % 4)));
            chk("rr_rdy",   64'(req_rdy_o),   64'(1 << (k % 4)));
            tick();
        end
        idle();
        for (int k = 0; k < 4; k++) tick();
        @(negedge clk);
        chk("rr_drained", 64'(cdb_vld_o), 64'h0);

        // Squash: MULT (mask 0010) and a matching incoming MULT are dropped
        offer(REQ_ALU,  20, 64'h20, 4'b0001);
        offer(REQ_MULT, 21, 64'h21, 4'b0010);
        tick();
        idle();
        rob_br_recovery_i = 1'b1;
        rob_br_tag_fix_i  = 4'b0010;
        offer(REQ_MULT, 22, 64'h22, 4'b0010);
        @(negedge clk);
        chk("sq_vld",   64'(cdb_vld_o),   64'h0);
        chk("sq_grant", 64'(cdb_grant_o), 64'h0);
        chk("sq_rdy",   64'(req_rdy_o),   64'he);
        tick();
        idle();
        @(negedge clk);
        chk("sq_alu_grant", 64'(cdb_grant_o), 64'h1);
        chk("sq_alu_tag",   64'(cdb_tag_o),   64'd20);
        tick();
        @(negedge clk);
        chk("sq_mult_gone", 64'(cdb_vld_o), 64'h0);

        // Resolve on a stored mask, then recovery on that bit must not squash
        offer(REQ_MULT, 31, 64'h31, 4'b0000);
        offer(REQ_LDST, 30, 64'hAAAA, 4'b0110);
        tick();
        idle();
        rob_br_pred_correct_i = 1'b1;
        rob_br_tag_fix_i      = 4'b0100;
        @(negedge clk);
        chk("res_mult_grant", 64'(cdb_grant_o), 64'h2);
        chk("res_mult_tag",   64'(cdb_tag_o),   64'd31);
        tick();
        idle();
        rob_br_recovery_i = 1'b1;
        rob_br_tag_fix_i  = 4'b0100;
        @(negedge clk);
        chk("res_rec_vld", 64'(cdb_vld_o), 64'h0);
        tick();
        idle();
        @(negedge clk);
        chk("res_ldst_grant", 64'(cdb_grant_o), 64'h4);
        chk("res_ldst_tag",   64'(cdb_tag_o),   64'd30);
        chk("res_ldst_value", cdb_value_o,      64'hAAAA);
        tick();

        // Resolve applied to a mask captured in the same cycle
        offer(REQ_BR, 33, 64'h33, 4'b0100);
        rob_br_pred_correct_i = 1'b1;
        rob_br_tag_fix_i      = 4'b0100;
        tick();
        idle();
        rob_br_recovery_i = 1'b1;
        rob_br_tag_fix_i  = 4'b0100;
        @(negedge clk);
        chk("cap_rec_vld", 64'(cdb_vld_o), 64'h0);
        tick();
        idle();
        @(negedge clk);
        chk("cap_br_grant", 64'(cdb_grant_o), 64'h8);
        chk("cap_br_tag",   64'(cdb_tag_o),   64'd33);
        tick();

        // Backpressure: 10 ALU packets against three always-valid requesters
        n_sent    = 0;
        n_recv    = 0;
        saw_stall = 1'b0;
        offer(REQ_ALU, 50, 64'd256, 4'b0000);
        for (int i = 1; i < 4; i++) offer(i, 40 + i, 64'(i), 4'b0000);
        for (int cyc = 0; cyc < 200 && n_recv < 10; cyc++) begin
            @(negedge clk);
            fire = req_vld_i[0] && req_rdy_o[0];
            if (!req_rdy_o[0]) saw_stall = 1'b1;
            if (cdb_grant_o[0]) begin
                chk("bp_tag",   64'(cdb_tag_o), 64'(50 + n_recv));
                chk("bp_value", cdb_value_o,    64'(256 + n_recv));
                n_recv++;
            end
            tick();
            if (fire) begin
                n_sent++;
                if (n_sent < 10) offer(REQ_ALU, 50 + n_sent, 64'(256 + n_sent), 4'b0000);
                else req_vld_i[0] = 1'b0;
            end
        end
        chk("bp_recv",  64'(n_recv),    64'd10);
        chk("bp_sent",  64'(n_sent),    64'd10);
        chk("bp_stall", 64'(saw_stall), 64'h1);
        idle();
        for (int k = 0; k < 4; k++) tick();
        @(negedge clk);
        chk("bp_drained", 64'(cdb_vld_o), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cdb_arb.md
CDB_ARB -- requirements
Module: cdb_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of writeback requesters (index 0 = ALU, 1 = MULT, 2 = LDST, 3 = BR).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high (name the clock and reset ports as the codebase does; the polarity and synchronicity here are fixed).
REQ-003 clk  input  1  clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req_vld_i  input  NUM_REQ  per-requester result valid.
REQ-006 req_tag_i  input  NUM_REQ x `PRF_IDX_W  destination physical register.
REQ-007 req_value_i  input  NUM_REQ x 64  result value.
REQ-008 req_rob_idx_i  input  NUM_REQ x (`ROB_IDX_W+1)  ROB index.
REQ-009 req_br_mask_i  input  NUM_REQ x `BR_MASK_W  branch mask.
REQ-010 req_rdy_o  output  NUM_REQ  buffer can accept this cycle.
REQ-011 rob_br_recovery_i / rob_br_pred_correct_i  input  1 each  mispredict squash / correct-prediction resolve.
REQ-012 rob_br_tag_fix_i  input  `BR_MASK_W  one-hot tag of the resolving branch.
REQ-013 cdb_vld_o, cdb_tag_o, cdb_value_o, cdb_rob_idx_o  output  1 / `PRF_IDX_W / 64 / `ROB_IDX_W+1  broadcast packet.
REQ-014 cdb_grant_o  output  NUM_REQ  one-hot id of the broadcasting requester.

Function
REQ-015 Each requester SHALL own one holding entry: valid bit, tag, value, rob_idx and br_mask.
REQ-016 req_rdy_o[i] SHALL be 1 when entry i is empty, or when it is granted this cycle.
REQ-017 A transfer SHALL occur when req_vld_i[i] and req_rdy_o[i] are both 1; the data is captured at the next clock edge.
REQ-018 A requester seeing req_rdy_o[i]=0 SHALL hold its inputs; the arbiter SHALL never drop an unsquashed packet.
REQ-019 Arbitration SHALL pick exactly one valid entry per cycle, round-robin.
REQ-020 The round-robin search SHALL start at the index following the last grant; the pointer SHALL advance only on a grant.
REQ-021 The cdb_* outputs SHALL be combinational from the granted entry, giving 1-cycle latency from acceptance to broadcast.
REQ-022 With no valid entry, cdb_vld_o, cdb_grant_o, cdb_tag_o, cdb_value_o and cdb_rob_idx_o SHALL be 0.
REQ-023 On rob_br_recovery_i, every entry with (br_mask & rob_br_tag_fix_i) != 0 SHALL be invalidated at the next edge.
REQ-024 On rob_br_recovery_i, an input with a matching mask SHALL be discarded; it is still handshaken (rdy=1).
REQ-025 On rob_br_recovery_i, cdb_vld_o and cdb_grant_o SHALL be 0 for the whole cycle, and the RR pointer SHALL hold.
REQ-026 On rob_br_pred_correct_i, the rob_br_tag_fix_i bit SHALL be cleared in all stored masks and in masks captured that cycle.
REQ-027 If both recovery and pred_correct are asserted, recovery SHALL take precedence.
REQ-028 When an entry is granted and refilled in the same cycle, the new packet SHALL occupy the entry next cycle with no bubble.

Reset
REQ-029 When rst=1 at a clock edge, all entries SHALL become invalid and the RR pointer SHALL become 0.
REQ-030 While rst=1, req_rdy_o SHALL be all-0 and all cdb_* outputs SHALL be 0.
REQ-031 Reset mid-operation SHALL discard buffered packets without broadcast.

Configuration
REQ-032 With CDB_ARB_FIXED_PRI_EN defined, arbitration SHALL be fixed priority, lowest index first, and no RR pointer SHALL exist.
REQ-033 Without CDB_ARB_FIXED_PRI_EN, arbitration SHALL be round-robin as in REQ-019 to REQ-020.

Structure
REQ-034 Package cdb_pkg SHALL hold the cdb_pkt_t struct (vld, tag, value, rob_idx, br_mask) and the requester index constants.
REQ-035 Grant selection SHALL be a sub-module cdb_rr_arb (NUM_REQ-wide request/grant plus pointer); the top holds the buffers, squash logic and output mux.

Verification
REQ-036 Single packet: ALU offers tag=5, value=0x1234 at cycle 0 -> at cycle 1 cdb_vld_o=1, cdb_tag_o=5, cdb_grant_o=0001.
REQ-037 Fairness: all 4 requesters held valid continuously -> grants rotate 0,1,2,3,0; no requester waits more than 3 cycles.
REQ-038 Squash: MULT buffered with mask 0010, recovery with tag_fix 0010 -> cdb_vld_o=0 that cycle and the entry is gone next cycle; the ALU entry with mask 0001 broadcasts next cycle.
REQ-039 Resolve: LDST buffered with mask 0110, pred_correct with tag_fix 0100 -> the later broadcast is intact; a later recovery on 0100 does not squash it.
REQ-040 Backpressure: ALU issues every cycle while 3 others are also valid -> req_rdy_o[0] deasserts, and all 10 ALU packets are broadcast in order with none lost.
REQ-041 Reset: rst asserted with 3 entries full -> the next cycle shows no broadcast, all rdy=0; after deassertion the pointer restarts at 0.
